// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard unit: stall causes, memory FSM
// states and the per-operand-class readiness thresholds.
package hazard_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_DATA   = 2'd1,
        CAUSE_BRANCH = 2'd2,
        CAUSE_MEM    = 2'd3
    } cause_e;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUSY = 1'b1
    } mem_state_e;

    // A source stalls while its register's counter is above its class threshold.
    localparam int unsigned THR_BRANCH = 32'd0;
    localparam int unsigned THR_OTHER  = 32'd1;
    localparam int unsigned THR_STORE  = 32'd2;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/hazard_mem_busy_fsm.sv
// Holds the front end while a memory access occupies the shared memory port,
// for MEM_BUSY_CYCLES cycles per access; a new access while busy restarts the hold.
module hazard_mem_busy_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_BUSY_CYCLES = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic mem_start,
    output logic mem_stall
);

    localparam int REM_W = (MEM_BUSY_CYCLES < 2) ? 1 : $clog2(MEM_BUSY_CYCLES + 1);
    localparam logic [REM_W-1:0] RELOAD   = REM_W'(MEM_BUSY_CYCLES - 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [REM_W-1:0] REM_ZERO = REM_W'(0);
    localparam bit               HAS_BUSY = (MEM_BUSY_CYCLES > 1);

    mem_state_e        state_r;
    logic [REM_W-1:0]  remain_r;

    // State and remaining-cycle counter; BUSY covers the cycles after the starting one.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r  <= MS_IDLE;
            remain_r <= REM_ZERO;
        end else begin
            case (state_r)
                MS_IDLE: begin
                    if (mem_start && HAS_BUSY) begin
                        state_r  <= MS_BUSY;
                        remain_r <= RELOAD;
                    end else begin
                        state_r  <= MS_IDLE;
                        remain_r <= remain_r;
                    end
                end
                MS_BUSY: begin
                    if (mem_start) begin
                        state_r  <= MS_BUSY;
                        remain_r <= RELOAD;
                    end else if (remain_r == REM_ONE) begin
                        state_r  <= MS_IDLE;
                        remain_r <= REM_ZERO;
                    end else begin
                        state_r  <= MS_BUSY;
                        remain_r <= remain_r - REM_ONE;
                    end
                end
                default: begin
                    state_r  <= MS_IDLE;
                    remain_r <= REM_ZERO;
                end
            endcase
        end
    end

    assign mem_stall = mem_start | (state_r == MS_BUSY);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Per-register readiness scoreboard driving PC / IF/ID enables and the ID/EX bubble.
// Optional HAZARD_PERF_EN adds saturating stall-cycle counters per cause.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int ALU_LAT         = 0,
    parameter int LOAD_LAT        = 1,
    parameter int MEM_BUSY_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic                  issue_reg_write,
    input  logic                  issue_mem_read,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_branch,
    input  logic                  id_mem_write,
    input  logic                  id_flush,
    input  logic                  mem_start,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  hazard_zero,
    output logic [1:0]            stall_cause
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_data_stall,
    output logic [31:0]           perf_branch_stall,
    output logic [31:0]           perf_mem_stall
`endif
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int RDY_W    = $clog2(LOAD_LAT + ALU_LAT + 3);

    localparam logic [RDY_W-1:0] RDY_ZERO = RDY_W'(0);
    localparam logic [RDY_W-1:0] RDY_ONE  = RDY_W'(1);
    localparam logic [RDY_W-1:0] LOAD_SET = RDY_W'(LOAD_LAT + 1);
    localparam logic [RDY_W-1:0] ALU_SET  = RDY_W'(ALU_LAT + 1);
    localparam logic [RDY_W-1:0] THR_B    = RDY_W'(THR_BRANCH);
    localparam logic [RDY_W-1:0] THR_O    = RDY_W'(THR_OTHER);
    localparam logic [RDY_W-1:0] THR_S    = RDY_W'(THR_STORE);

    logic [RDY_W-1:0] rdy_r [NUM_REGS];
    logic [RDY_W-1:0] rs_rdy_s, rt_rdy_s, thr_rs_s, thr_rt_s;
    logic             src_hit_s, data_stall_s, branch_stall_s, mem_stall_s, write_s;

    hazard_mem_busy_fsm #(
        .MEM_BUSY_CYCLES(MEM_BUSY_CYCLES)
    ) u_mem_busy (
        .clock    (clock),
        .reset_n  (reset_n),
        .mem_start(mem_start),
        .mem_stall(mem_stall_s)
    );

    // Source readiness and per-class thresholds; a store's rt is only needed in MEM.
    always_comb begin
        rs_rdy_s = (id_rs == {REG_ADDR_W{1'b0}}) ? RDY_ZERO : rdy_r[id_rs];
        rt_rdy_s = (id_rt == {REG_ADDR_W{1'b0}}) ? RDY_ZERO : rdy_r[id_rt];
        thr_rs_s = id_branch ? THR_B : THR_O;
        thr_rt_s = id_branch ? THR_B : (id_mem_write ? THR_S : THR_O);
        src_hit_s = ((id_uses_rs & (rs_rdy_s > thr_rs_s)) |
                     (id_uses_rt & (rt_rdy_s > thr_rt_s))) & ~id_flush;
        data_stall_s   = src_hit_s & ~id_branch;
        branch_stall_s = src_hit_s & id_branch;
    end

    // Stall outputs with data > branch > memory priority; reset forces free-running.
    always_comb begin
        if (!reset_n) begin
            stall_cause = CAUSE_NONE;
        end else if (data_stall_s) begin
            stall_cause = CAUSE_DATA;
        end else if (branch_stall_s) begin
            stall_cause = CAUSE_BRANCH;
        end else if (mem_stall_s) begin
            stall_cause = CAUSE_MEM;
        end else begin
            stall_cause = CAUSE_NONE;
        end
        hazard_zero = (stall_cause != CAUSE_NONE);
        pc_write    = ~hazard_zero;
        if_id_write = ~hazard_zero;
    end

    assign write_s = issue_valid & ~hazard_zero & issue_reg_write &
                     (issue_dest != {REG_ADDR_W{1'b0}});

    // Scoreboard counters: a new writer loads its latency, all others count down to zero.
    always_ff @(posedge clock) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!reset_n || r == 0) begin
                rdy_r[r] <= RDY_ZERO;
            end else if (write_s && issue_dest == REG_ADDR_W'(r)) begin
                rdy_r[r] <= issue_mem_read ? LOAD_SET : ALU_SET;
            end else if (rdy_r[r] != RDY_ZERO) begin
                rdy_r[r] <= rdy_r[r] - RDY_ONE;
            end else begin
                rdy_r[r] <= rdy_r[r];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Stall-cycle counters, one per cause.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_data_stall   <= 32'd0;
            perf_branch_stall <= 32'd0;
            perf_mem_stall    <= 32'd0;
        end else begin
            case (stall_cause)
                CAUSE_DATA:   perf_data_stall   <= sat_inc32(perf_data_stall);
                CAUSE_BRANCH: perf_branch_stall <= sat_inc32(perf_branch_stall);
                CAUSE_MEM:    perf_mem_stall    <= sat_inc32(perf_mem_stall);
                default: begin
                    perf_data_stall   <= perf_data_stall;
                    perf_branch_stall <= perf_branch_stall;
                    perf_mem_stall    <= perf_mem_stall;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit (MEM_BUSY_CYCLES=3, other defaults).
module tb_hazard_scoreboard_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       issue_valid, issue_reg_write, issue_mem_read;
    logic [4:0] issue_dest, id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt, id_branch, id_mem_write, id_flush, mem_start;
    logic       pc_write, if_id_write, hazard_zero;
    logic [1:0] stall_cause;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_data_stall, perf_branch_stall, perf_mem_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    hazard_scoreboard_unit #(
        .REG_ADDR_W(5), .ALU_LAT(0), .LOAD_LAT(1), .MEM_BUSY_CYCLES(3)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
        .issue_mem_read(issue_mem_read), .issue_dest(issue_dest),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_mem_write(id_mem_write), .id_flush(id_flush),
        .mem_start(mem_start), .pc_write(pc_write), .if_id_write(if_id_write),
        .hazard_zero(hazard_zero), .stall_cause(stall_cause)
`ifdef HAZARD_PERF_EN
        , .perf_data_stall(perf_data_stall), .perf_branch_stall(perf_branch_stall),
        .perf_mem_stall(perf_mem_stall)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks {pc_write,if_id_write,hazard_zero,stall_cause} mid-cycle, then crosses the edge.
    task automatic expect_out(input string tag, input logic stall, input logic [1:0] cause);
        @(negedge clock);
        check_val(tag, {27'd0, pc_write, if_id_write, hazard_zero, stall_cause},
                       {27'd0, ~stall, ~stall, stall, cause});
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        issue_valid = 1'b0; issue_reg_write = 1'b0; issue_mem_read = 1'b0; issue_dest = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_branch = 1'b0; id_mem_write = 1'b0; id_flush = 1'b0; mem_start = 1'b0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) tick();
    endtask

    task automatic issue(input logic [4:0] dest, input logic is_load);
        issue_valid = 1'b1; issue_reg_write = 1'b1; issue_mem_read = is_load; issue_dest = dest;
    endtask

    task automatic use_rs(input logic [4:0] r);
        id_uses_rs = 1'b1; id_rs = r;
    endtask

    task automatic use_rt(input logic [4:0] r);
        id_uses_rt = 1'b1; id_rt = r;
    endtask

    initial begin
        clr();
        reset_n = 1'b0;
        mem_start = 1'b1; use_rs(5'd8);
        expect_out("rst_out", 1'b0, 2'd0);
        reset_n = 1'b1;
        idle(1);

        // load -> use: exactly one bubble
        issue(5'd8, 1'b1);            expect_out("ld_issue", 1'b0, 2'd0);
        clr(); use_rs(5'd8);          expect_out("ld_use_t1", 1'b1, 2'd1);
                                      expect_out("ld_use_t2", 1'b0, 2'd0);
        idle(2);

        // ALU -> branch: one bubble
        issue(5'd9, 1'b0);            expect_out("alu_issue", 1'b0, 2'd0);
        clr(); id_branch = 1'b1; use_rs(5'd9);
                                      expect_out("alu_br_t1", 1'b1, 2'd2);
                                      expect_out("alu_br_t2", 1'b0, 2'd0);
        idle(2);

        // load -> branch: two bubbles
        issue(5'd9, 1'b1);            tick();
        clr(); id_branch = 1'b1; use_rt(5'd9);
                                      expect_out("ld_br_t1", 1'b1, 2'd2);
                                      expect_out("ld_br_t2", 1'b1, 2'd2);
                                      expect_out("ld_br_t3", 1'b0, 2'd0);
        idle(2);

        // load -> store data register: none; load -> store base register: one
        issue(5'd10, 1'b1);           tick();
        clr(); id_mem_write = 1'b1; use_rt(5'd10); use_rs(5'd29);
                                      expect_out("ld_sw_rt", 1'b0, 2'd0);
        idle(2);
        issue(5'd10, 1'b1);           tick();
        clr(); id_mem_write = 1'b1; use_rs(5'd10); use_rt(5'd5);
                                      expect_out("ld_sw_base", 1'b1, 2'd1);
        idle(2);

        // $zero is never tracked
        issue(5'd0, 1'b1);            tick();
        clr(); use_rs(5'd0); use_rt(5'd0);
                                      expect_out("zero_use", 1'b0, 2'd0);
        id_branch = 1'b1;             expect_out("zero_br", 1'b0, 2'd0);
        idle(1);

        // flush masks the hazard but the scoreboard keeps counting
        issue(5'd8, 1'b1);            tick();
        clr(); use_rs(5'd8); id_flush = 1'b1;
                                      expect_out("flush_lduse", 1'b0, 2'd0);
        id_flush = 1'b0; id_branch = 1'b1;
                                      expect_out("flush_sb_kept", 1'b1, 2'd2);
                                      expect_out("flush_br_t2", 1'b0, 2'd0);
        idle(2);

        // single memory access: three stall cycles
        mem_start = 1'b1;             expect_out("mem1_t0", 1'b1, 2'd3);
        mem_start = 1'b0;             expect_out("mem1_t1", 1'b1, 2'd3);
                                      expect_out("mem1_t2", 1'b1, 2'd3);
                                      expect_out("mem1_t3", 1'b0, 2'd0);

        // back-to-back accesses extend the hold
        mem_start = 1'b1;             expect_out("mem2_t0", 1'b1, 2'd3);
                                      expect_out("mem2_t1", 1'b1, 2'd3);
        mem_start = 1'b0;             expect_out("mem2_t2", 1'b1, 2'd3);
                                      expect_out("mem2_t3", 1'b1, 2'd3);
                                      expect_out("mem2_t4", 1'b0, 2'd0);
        idle(1);

        // cause priority, and flush leaves memory stalls in force
        issue(5'd8, 1'b1);            tick();
        clr(); use_rs(5'd8); mem_start = 1'b1;
                                      expect_out("prio_data_mem", 1'b1, 2'd1);
        clr(); use_rs(5'd8); id_branch = 1'b1;
                                      expect_out("prio_br_mem", 1'b1, 2'd2);
        clr(); id_flush = 1'b1;       expect_out("flush_mem", 1'b1, 2'd3);
        clr();                        expect_out("prio_done", 1'b0, 2'd0);

        // reset in the middle of BUSY
        mem_start = 1'b1;             expect_out("rst_busy_t0", 1'b1, 2'd3);
        mem_start = 1'b0; reset_n = 1'b0;
                                      expect_out("rst_busy_out", 1'b0, 2'd0);
        reset_n = 1'b1;               expect_out("rst_busy_idle", 1'b0, 2'd0);

        // two data stalls then three memory stalls
        issue(5'd8, 1'b1);            tick();
        clr(); use_rs(5'd8);          expect_out("perf_d1", 1'b1, 2'd1);
        clr(); issue(5'd9, 1'b1);     tick();
        clr(); use_rs(5'd9);          expect_out("perf_d2", 1'b1, 2'd1);
        clr(); mem_start = 1'b1;      expect_out("perf_m0", 1'b1, 2'd3);
        clr();                        expect_out("perf_m1", 1'b1, 2'd3);
                                      expect_out("perf_m2", 1'b1, 2'd3);
`ifdef HAZARD_PERF_EN
        check_val("perf_data", perf_data_stall, 32'd2);
        check_val("perf_branch", perf_branch_stall, 32'd0);
        check_val("perf_mem", perf_mem_stall, 32'd3);
`endif
        expect_out("perf_end", 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage. A per-register readiness scoreboard replaces fixed stage-tag comparisons, so load/ALU result latencies become parameters rather than being hard-coded. A small FSM holds the front end for a configurable number of cycles while a memory access occupies the shared memory port. Outputs drive the PC write enable, the IF/ID write enable and the ID/EX bubble mux.

## Interface
- `REG_ADDR_W`, 5: register index width; `NUM_REGS = 1 << REG_ADDR_W`.
- `ALU_LAT`, 0: extra cycles beyond EX before an ALU result can be forwarded.
- `LOAD_LAT`, 1: extra cycles beyond EX before load data can be forwarded.
- `MEM_BUSY_CYCLES`, 1: front-end stall length per memory access, ≥1.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: synchronous, active-low reset.
- `issue_valid` input 1: the ID instruction enters ID/EX at this edge.
- `issue_reg_write` input 1: the issuing instruction writes `issue_dest`.
- `issue_mem_read` input 1: the issuing instruction is a load.
- `issue_dest` input REG_ADDR_W: destination register of the issuing instruction.
- `id_rs`, `id_rt` input REG_ADDR_W: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` input 1: source-valid qualifiers.
- `id_branch` input 1: ID instruction is a branch that compares operands in ID.
- `id_mem_write` input 1: ID instruction is a store; rt is consumed in MEM.
- `id_flush` input 1: the ID instruction is being squashed this cycle.
- `mem_start` input 1: a load or store occupies EX/MEM this cycle.
- `pc_write` output 1: PC update enable.
- `if_id_write` output 1: IF/ID update enable.
- `hazard_zero` output 1: zero the ID/EX control signals (bubble).
- `stall_cause` output 2: 0 none, 1 data, 2 branch, 3 memory.

## Operation
- Scoreboard: one counter `rdy[r]` per register, width `$clog2(LOAD_LAT+ALU_LAT+3)`. Register 0 is never tracked and always reads 0.
- Update at each edge where `issue_valid & ~hazard_zero & issue_reg_write & issue_dest!=0`:
  - Load: `rdy[dest] <= LOAD_LAT+1`.
  - Otherwise: `rdy[dest] <= ALU_LAT+1`.
- Every other nonzero counter decrements by 1 and saturates at 0.
- Load of the issuing register overrides its decrement in the same cycle.
- Required distance `need(src)`, checked only when the source-use qualifier is set:
  - Branch operand: stall while `rdy > 0`.
  - Store rt: stall while `rdy > 2`.
  - Any other operand: stall while `rdy > 1`.
- data hazard = a non-branch source stalls; branch hazard = `id_branch` and a source stalls.
- Memory FSM:
  - IDLE: a `mem_start` requests a stall this cycle. If `MEM_BUSY_CYCLES>1`, go to BUSY with `remain = MEM_BUSY_CYCLES-1`.
  - BUSY: request a stall every cycle and decrement `remain`; return to IDLE after the cycle in which `remain==1`.
  - `mem_start` while in BUSY reloads `remain = MEM_BUSY_CYCLES-1`.
- Any stall request sets `pc_write=0`, `if_id_write=0`, `hazard_zero=1`.
- `stall_cause` priority: data > branch > memory.
- `id_flush`: suppresses the data and branch stall requests only. Memory stalls still apply. The scoreboard is unaffected because in-flight writers still retire.

## Timing
- All outputs are combinational from the current scoreboard, FSM and inputs; there is no added latency.
- Default parameters give:
  - load→use: 1 bubble
  - ALU→branch: 1 bubble
  - load→branch: 2 bubbles
  - load→store-rt: 0 bubbles
- Reset: while `reset_n=0`, outputs are forced to `pc_write=1`, `if_id_write=1`, `hazard_zero=0`, `stall_cause=0`. At the reset edge all `rdy` clear and the FSM goes to IDLE with `remain=0`.
- Reset mid-BUSY abandons the memory stall at that edge.

## Configuration
- `HAZARD_PERF_EN` defined:
  - Adds three 32-bit saturating output counters `perf_data_stall`, `perf_branch_stall`, `perf_mem_stall`.
  - Each cycle, the counter selected by `stall_cause` increments.
  - Counters clear on reset.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- `hazard_pkg` holds the cause encodings (`CAUSE_NONE/DATA/BRANCH/MEM`), the FSM state encodings (`MS_IDLE`, `MS_BUSY`) and the operand-class thresholds (0/1/2).
- Sub-module `hazard_mem_busy_fsm`: inputs `clock`, `reset_n`, `mem_start`; output the stall request. It is instanced once.

## Test plan
- Load `$t0` issued at cycle t; `add` reading `$t0` in ID at t+1 → `hazard_zero=1`, `stall_cause=1` at t+1 only; no stall at t+2.
- ALU write `$t1` at t; `beq $t1` in ID at t+1 → one bubble, cause 2. With a load instead → bubbles at t+1 and t+2.
- Load `$t2` then `sw $t2` immediately → no stall. Dest `$zero` load then a `$zero` use → no stall.
- `MEM_BUSY_CYCLES=3`, `mem_start` at t → stall t..t+2, cause 3. A second `mem_start` at t+1 → stall extends through t+3.
- Load-use hazard coincident with `id_flush=1` → no stall. `reset_n=0` mid-BUSY → outputs are no-stall and the next cycle is IDLE.
- `HAZARD_PERF_EN`: 2 data + 3 memory stall cycles → `perf_data_stall=2`, `perf_mem_stall=3`, `perf_branch_stall=0`.
